// File: rtl/cpu_pkg.sv
// Shared types and constants for the WISC pipeline front end.
// Pure declarations: no latency, no backpressure.
package cpu_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [15:0]         instr_t;
    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t        RESET_PC   = 16'h0000;
    localparam instr_t     NOP_INSTR  = 16'h0000;
    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } fetch_state_t;

    function automatic logic is_opcode(input instr_t instr, input logic [3:0] opcode);
        return instr[15:12] == opcode;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
// imem_req/imem_addr held by the master until the slave answers with imem_rdy.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic   imem_req;
    pc_t    imem_addr;
    logic   imem_rdy;
    instr_t imem_data;

    modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);

endinterface

// File: rtl/addsub.sv
// 16-bit adder/subtractor with signed-overflow flag.
// Combinational, no backpressure.
module ADDSUB (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovfl
);

    logic [15:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {15'd0, sub};
    assign ovfl  = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over flush, otherwise holds.
// 1-cycle register, no backpressure of its own (hold is the caller's choice).
module if_id_reg #(
    parameter cpu_pkg::instr_t NOP_VAL = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  cpu_pkg::instr_t instr_in,
    input  cpu_pkg::pc_t    pc_in,
    output cpu_pkg::instr_t instr,
    output cpu_pkg::pc_t    pc,
    output logic            valid
);
    import cpu_pkg::*;

    instr_t instr_q, instr_d;
    pc_t    pc_q, pc_d;
    logic   valid_q, valid_d;

    // A flush keeps the address so PC_control still sees the last fetched PC.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end else if (flush) begin
            instr_d = NOP_VAL;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_VAL;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction fetch: owns PC, issues imem requests, fills IF/ID; 1 cycle imem_rdy -> IF/ID.
// Request held until imem_rdy; stall holds PC and IF/ID, redirect squashes an in-flight access.
module fetch_stage #(
    parameter cpu_pkg::pc_t    RESET_PC   = 16'h0000,
    parameter cpu_pkg::instr_t NOP_INSTR  = 16'h0000,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  cpu_pkg::pc_t       redirect_pc,
    fetch_stage_if.master      imem,
    output cpu_pkg::instr_t    if_id_instr,
    output cpu_pkg::pc_t       if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);
    import cpu_pkg::*;

    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d;
    pc_t          pend_pc_q, pend_pc_d;
    logic         halted_q, halted_d;
    pc_t          pc_plus2;
    logic         unused_ovfl;
    logic         ifid_load, ifid_flush;

    ADDSUB u_pc_inc (
        .a    (pc_q),
        .b    (16'd2),
        .sub  (1'b0),
        .sum  (pc_plus2),
        .ovfl (unused_ovfl)
    );

    assign imem.imem_req  = (state_q != ST_HALT);
    assign imem.imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        halted_d   = halted_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem.imem_rdy) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Address must stay stable until the memory answers.
                        pend_pc_d = redirect_pc;
                        state_d   = ST_SQUASH;
                    end
                end else if (stall) begin
                    ifid_flush = 1'b0;
                end else if (imem.imem_rdy) begin
                    ifid_load = 1'b1;
                    if (is_opcode(imem.imem_data, HLT_OPCODE)) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            ST_SQUASH: begin
                ifid_flush = 1'b1;
                if (imem.imem_rdy) begin
                    pc_d    = redirect ? redirect_pc : pend_pc_q;
                    state_d = ST_RUN;
                end else if (redirect) begin
                    pend_pc_d = redirect_pc;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = redirect_pc;
                    halted_d   = 1'b0;
                    state_d    = ST_RUN;
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 16'h0000;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            halted_q  <= halted_d;
        end
    end

    if_id_reg #(
        .NOP_VAL (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .instr_in (imem.imem_data),
        .pc_in    (pc_q),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .valid    (if_id_valid)
    );

    assign halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by random traffic, all checked against a rule-level fetch model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_stage_if mem_if ();

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (mem_if),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: where fetch is heading and what the IF/ID register should show.
    logic [15:0] m_pc;
    logic [15:0] m_target;
    bit          m_halt;
    bit          m_squash;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    bit          m_valid;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_target = 16'h0000;
        m_halt   = 0;
        m_squash = 0;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_valid  = 0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000;
        m_valid = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit rd, input logic [15:0] rpc,
                              input bit ry, input logic [15:0] d);
        if (r) begin
            model_reset();
        end else if (m_halt) begin
            if (rd) begin
                m_pc   = rpc;
                m_halt = 0;
                model_bubble();
            end else if (!s) begin
                model_bubble();
            end
        end else if (m_squash) begin
            model_bubble();
            if (ry) begin
                m_pc     = rd ? rpc : m_target;
                m_squash = 0;
            end else if (rd) begin
                m_target = rpc;
            end
        end else if (rd) begin
            model_bubble();
            if (ry) m_pc = rpc;
            else begin
                m_target = rpc;
                m_squash = 1;
            end
        end else if (s) begin
            // IF/ID and PC frozen; any returning word is simply refetched later.
        end else if (ry) begin
            m_instr = d;
            m_ipc   = m_pc;
            m_valid = 1;
            if (d[15:12] == 4'hF) m_halt = 1;
            else m_pc = 16'((32'(m_pc) + 2) % 65536);
        end else begin
            model_bubble();
        end
    endtask

    task automatic check_regs();
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        chk("halted", {15'd0, halted}, {15'd0, m_halt});
    endtask

    // One clock: drive, check the request side before the edge, then the registers after it.
    task automatic cycle(input bit r, input bit s, input bit rd, input logic [15:0] rpc,
                         input bit ry, input logic [15:0] d);
        rst              = r;
        stall            = s;
        redirect         = rd;
        redirect_pc      = rpc;
        mem_if.imem_rdy  = ry;
        mem_if.imem_data = d;
        #1;
        chk("imem_req", {15'd0, mem_if.imem_req}, {15'd0, !m_halt});
        chk("imem_addr", mem_if.imem_addr, m_pc);
        model_step(r, s, rd, rpc, ry, d);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        rst              = 1'b1;
        stall            = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = 16'h0000;
        mem_if.imem_rdy  = 1'b0;
        mem_if.imem_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_ipc", if_id_pc, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_req", {15'd0, mem_if.imem_req}, 16'd1);
        chk("rst_addr", mem_if.imem_addr, 16'h0000);

        // Zero-wait memory streams one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 16'h0, 1, 16'h1000 + 16'(i));
            chk("s1_ipc", if_id_pc, 16'(2 * i));
            chk("s1_valid", {15'd0, if_id_valid}, 16'd1);
        end

        // Three wait states at 0x0004.
        cycle(1, 0, 0, 16'h0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0, 1, 16'h2000);
        cycle(0, 0, 0, 16'h0, 1, 16'h2002);
        for (int i = 0; i < 3; i++) begin
            chk("s2_addr_hold", mem_if.imem_addr, 16'h0004);
            cycle(0, 0, 0, 16'h0, 0, 16'hDEAD);
            chk("s2_bubble", {15'd0, if_id_valid}, 16'd0);
        end
        chk("s2_addr_hold", mem_if.imem_addr, 16'h0004);
        cycle(0, 0, 0, 16'h0, 1, 16'h2004);
        chk("s2_ipc", if_id_pc, 16'h0004);
        chk("s2_instr", if_id_instr, 16'h2004);

        // Redirect while the access to 0x0008 is outstanding.
        cycle(0, 0, 0, 16'h0, 1, 16'h2006);
        cycle(0, 0, 1, 16'h0040, 0, 16'h0);
        chk("s3_addr_stable", mem_if.imem_addr, 16'h0008);
        cycle(0, 0, 0, 16'h0, 1, 16'h5555);
        chk("s3_discard", {15'd0, if_id_valid}, 16'd0);
        chk("s3_new_addr", mem_if.imem_addr, 16'h0040);
        cycle(0, 0, 0, 16'h0, 1, 16'h3040);
        chk("s3_ipc", if_id_pc, 16'h0040);

        // Stall with a coincident imem_rdy at 0x0010.
        cycle(0, 0, 1, 16'h000E, 1, 16'h9999);
        cycle(0, 0, 0, 16'h0, 1, 16'h400E);
        cycle(0, 1, 0, 16'h0, 1, 16'h7777);
        chk("s4_hold_instr", if_id_instr, 16'h400E);
        chk("s4_hold_ipc", if_id_pc, 16'h000E);
        chk("s4_addr", mem_if.imem_addr, 16'h0010);
        cycle(0, 0, 0, 16'h0, 1, 16'h4010);
        chk("s4_refetch", if_id_pc, 16'h0010);

        // HLT then redirect out of it.
        cycle(0, 0, 1, 16'h0020, 1, 16'h0);
        cycle(0, 0, 0, 16'h0, 1, 16'hF000);
        chk("s5_halted", {15'd0, halted}, 16'd1);
        chk("s5_req", {15'd0, mem_if.imem_req}, 16'd0);
        chk("s5_pc", mem_if.imem_addr, 16'h0020);
        chk("s5_hlt_instr", if_id_instr, 16'hF000);
        cycle(0, 0, 0, 16'h0, 1, 16'h1111);
        chk("s5_hlt_bubble", {15'd0, if_id_valid}, 16'd0);
        cycle(0, 0, 1, 16'h0030, 0, 16'h0);
        chk("s5_resume", {15'd0, halted}, 16'd0);
        chk("s5_addr", mem_if.imem_addr, 16'h0030);
        cycle(0, 0, 0, 16'h0, 1, 16'h5030);
        chk("s5_ipc", if_id_pc, 16'h0030);

        // PC wrap, then reset in the middle of a wait.
        cycle(0, 0, 1, 16'hFFFE, 1, 16'h0);
        cycle(0, 0, 0, 16'h0, 1, 16'h6FFE);
        chk("s6_wrap", mem_if.imem_addr, 16'h0000);
        cycle(0, 0, 1, 16'h0100, 1, 16'h0);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        cycle(1, 0, 0, 16'h0, 1, 16'h7100);
        chk("s6_rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("s6_rst_pc", mem_if.imem_addr, 16'h0000);
        cycle(0, 0, 0, 16'h0, 1, 16'h8000);
        chk("s6_ipc", if_id_pc, 16'h0000);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  16'($urandom) & 16'hFFFE,
                  $urandom_range(0, 2) != 0,
                  16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
